// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and encodings for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  localparam int unsigned INSTRUCTION_LEN        = 32;
  localparam int unsigned INSTRUCTION_MEM_SIZE   = 1024;
  localparam int unsigned DEFAULT_MAX_LOAD_BURST = 4;

  localparam logic [31:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_SKIP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_t;

endpackage

// File: rtl/imem_grant_sel.sv
// Loader-first priority selector with a saturating burst counter that
// hands the port to fetch once the loader has taken MAX_LOAD_BURST grants.
module imem_grant_sel
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOAD_BURST = DEFAULT_MAX_LOAD_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_fetch_req,
  input  logic i_load_req,
  output logic o_fetch_gnt,
  output logic o_load_gnt
);

  localparam int unsigned CNT_W = $clog2(MAX_LOAD_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOAD_BURST);

  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_fetch_turn;

  assign w_fetch_turn = i_fetch_req && (r_burst_cnt == CNT_MAX);

  always_comb begin
    o_load_gnt  = 1'b0;
    o_fetch_gnt = 1'b0;
    if (i_en) begin
      o_load_gnt  = i_load_req && !w_fetch_turn;
      o_fetch_gnt = i_fetch_req && (!i_load_req || w_fetch_turn);
    end
  end

  // Counts loader grants that made a waiting fetch stand aside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (!i_fetch_req || o_fetch_gnt) begin
      r_burst_cnt <= '0;
    end else if (o_load_gnt && (r_burst_cnt != CNT_MAX)) begin
      r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between fetch (reads) and the
// program loader (writes); one access per two cycles, screened for range.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = INSTRUCTION_LEN,
  parameter int unsigned DATA_W         = INSTRUCTION_LEN,
  parameter int unsigned MEM_SIZE       = INSTRUCTION_MEM_SIZE,
  parameter int unsigned MAX_LOAD_BURST = DEFAULT_MAX_LOAD_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] LAST_WORD = AW1'(MEM_SIZE - 4);
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR);

  state_t            r_state;
  req_t              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_fetch_valid;
  logic              r_fetch_err;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_en;
  logic              w_fetch_sel;
  logic              w_load_sel;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_addr_bad;

  assign w_en = (r_state == ST_IDLE) && !rst;

  imem_grant_sel #(
    .MAX_LOAD_BURST(MAX_LOAD_BURST)
  ) u_grant_sel (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en),
    .i_fetch_req(fetch_req),
    .i_load_req (load_req),
    .o_fetch_gnt(w_fetch_sel),
    .o_load_gnt (w_load_sel)
  );

  // Range compare is one bit wider so high addresses cannot wrap into range.
  assign w_gnt_addr = w_load_sel ? load_addr : fetch_addr;
  assign w_addr_bad = (w_gnt_addr[1:0] != 2'b00) || ({1'b0, w_gnt_addr} > LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_req         <= REQ_FETCH;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fetch_sel || w_load_sel) begin
            r_addr <= w_gnt_addr;
            r_req  <= w_load_sel ? REQ_LOAD : REQ_FETCH;
            if (w_load_sel) begin
              r_wdata <= load_data;
            end
            if (w_addr_bad) begin
              r_state <= ST_SKIP;
            end else begin
              r_state <= w_load_sel ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ: begin
          r_fetch_data  <= mem_rdata;
          r_fetch_valid <= !fetch_flush;
          r_state       <= ST_IDLE;
        end
        ST_WRITE: begin
          r_load_done <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_SKIP: begin
          if (r_req == REQ_LOAD) begin
            r_load_done <= 1'b1;
            r_load_err  <= 1'b1;
          end else begin
            r_fetch_data  <= NOP_WORD;
            r_fetch_valid <= !fetch_flush;
            r_fetch_err   <= !fetch_flush;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_gnt   = w_fetch_sel;
  assign load_gnt    = w_load_sel;
  // A flush in the response cycle still kills the pulse.
  assign fetch_valid = r_fetch_valid && !fetch_flush;
  assign fetch_err   = r_fetch_err && !fetch_flush;
  assign fetch_data  = r_fetch_data;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_read    = (r_state == ST_READ) && !rst;
  assign mem_write   = (r_state == ST_WRITE) && !rst;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and randomized bench for imem_port_arbiter against a cycle-level
// transaction model with its own reference memory.
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MEM_SIZE       = 1024;
  localparam int unsigned MAX_LOAD_BURST = 4;
  localparam logic [31:0] NOP            = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, fetch_gnt, fetch_valid, fetch_err;
  logic [31:0] fetch_addr, fetch_data;
  logic        load_req, load_gnt, load_done, load_err;
  logic [31:0] load_addr, load_data;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE), .MAX_LOAD_BURST(MAX_LOAD_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_gnt(load_gnt), .load_done(load_done), .load_err(load_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Physical memory seen by the DUT, and the bench's own expectation of it.
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = env_mem[mem_address[9:2]];

  int checks = 0;
  int failures = 0;

  // Model state: an access occupies one cycle after its grant.
  bit          m_busy, m_is_load, m_bad;
  logic [31:0] m_addr, m_data, m_maddr, m_fdata;
  int          m_burst;
  bit          p_f, p_ferr, p_l, p_lerr;
  bit          fg_done, lg_done;
  bit          flush_mode, rst_mode, rnd_mode;
  logic [31:0] fq[$];
  logic [31:0] lqa[$];
  logic [31:0] lqd[$];
  string       glog;
  int          gcyc[$];
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_burst = 0; m_maddr = '0; m_fdata = '0;
    p_f = 0; p_ferr = 0; p_l = 0; p_lerr = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
      1:       return MEM_SIZE - 4 + ($urandom_range(0, 3) << 2);
      2:       return 32'hFFFF_FFFC;
      default: return $urandom_range(0, 255) << 2;
    endcase
  endfunction

  // Called just after a rising edge: retire granted requests, raise new ones.
  task automatic set_inputs();
    if (fg_done) begin fetch_req = 0; fg_done = 0; end
    if (lg_done) begin load_req = 0; lg_done = 0; end
    if (!fetch_req && fq.size() > 0) begin fetch_req = 1; fetch_addr = fq.pop_front(); end
    if (!load_req && lqa.size() > 0) begin
      load_req = 1; load_addr = lqa.pop_front(); load_data = lqd.pop_front();
    end
    rst = (rst_mode && m_busy && m_is_load) || (rnd_mode && $urandom_range(0, 63) == 0);
    fetch_flush = (flush_mode && m_busy && !m_is_load) || (rnd_mode && $urandom_range(0, 7) == 0);
  endtask

  task automatic run_cycle();
    bit exp_fg, exp_lg, exp_rd, exp_wr, nf, nfe, nl, nle;
    set_inputs();
    @(negedge clk);
    exp_fg = 0; exp_lg = 0;
    if (!m_busy && !rst) begin
      if (load_req && !(fetch_req && m_burst == MAX_LOAD_BURST)) exp_lg = 1;
      else if (fetch_req) exp_fg = 1;
    end
    exp_rd = m_busy && !m_is_load && !m_bad && !rst;
    exp_wr = m_busy && m_is_load && !m_bad && !rst;
    chk1("load_gnt", load_gnt, exp_lg);
    chk1("fetch_gnt", fetch_gnt, exp_fg);
    chk1("mem_read", mem_read, exp_rd);
    chk1("mem_write", mem_write, exp_wr);
    if (exp_wr) chk("mem_wdata", mem_wdata, m_data);
    chk("mem_address", mem_address, m_maddr);
    chk1("busy", busy, m_busy);
    chk1("fetch_valid", fetch_valid, p_f && !fetch_flush);
    chk1("fetch_err", fetch_err, p_f && p_ferr && !fetch_flush);
    chk("fetch_data", fetch_data, m_fdata);
    chk1("load_done", load_done, p_l);
    chk1("load_err", load_err, p_l && p_lerr);
    if (mem_write === 1'b1) env_mem[mem_address[9:2]] = mem_wdata;
    if (rst) begin
      model_reset();
    end else begin
      nf = 0; nfe = 0; nl = 0; nle = 0;
      if (m_busy) begin
        if (m_is_load) begin
          if (!m_bad) ref_mem[m_addr[9:2]] = m_data;
          nl = 1; nle = m_bad;
        end else begin
          m_fdata = m_bad ? NOP : ref_mem[m_addr[9:2]];
          nf = !fetch_flush; nfe = m_bad;
        end
        m_busy = 0;
      end else if (exp_fg || exp_lg) begin
        m_busy = 1; m_is_load = exp_lg;
        m_addr = exp_lg ? load_addr : fetch_addr;
        m_maddr = m_addr;
        if (exp_lg) m_data = load_data;
        m_bad = (m_addr[1:0] != 2'b00) || (64'(m_addr) > 64'(MEM_SIZE) - 64'd4);
        glog = {glog, exp_lg ? "L" : "F"};
        gcyc.push_back(cyc);
      end
      if (!fetch_req || exp_fg) m_burst = 0;
      else if (exp_lg && m_burst < MAX_LOAD_BURST) m_burst++;
      p_f = nf; p_ferr = nfe; p_l = nl; p_lerr = nle;
    end
    if (exp_fg) fg_done = 1;
    if (exp_lg) lg_done = 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n = 0;
    while ((fq.size() > 0 || lqa.size() > 0 || fetch_req || load_req || m_busy || p_f || p_l)
           && n < bound) begin
      run_cycle();
      n++;
    end
    checks++;
    assert (n < bound) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d cycles expected=<%0d", tag, n, bound);
    end
  endtask

  initial begin
    logic [31:0] old_word;
    rst = 1; fetch_req = 0; fetch_addr = '0; fetch_flush = 0;
    load_req = 0; load_addr = '0; load_data = '0;
    fg_done = 0; lg_done = 0; flush_mode = 0; rst_mode = 0; rnd_mode = 0;
    m_is_load = 0; m_bad = 0; m_addr = '0; m_data = '0; glog = "";
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    env_mem[1] = 32'hE3A0_0014;
    ref_mem[1] = 32'hE3A0_0014;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state
    run_cycle();
    chk("reset_wdata", mem_wdata, 32'h0);

    // Plain fetch of word 1
    fq.push_back(32'h4);
    run_until_idle("fetch4", 20);
    chk("fetch4_data", fetch_data, 32'hE3A0_0014);

    // Load then fetch back
    lqa.push_back(32'h18); lqd.push_back(32'h1234_5678);
    run_until_idle("load18", 20);
    fq.push_back(32'h18);
    run_until_idle("fetch18", 20);
    chk("fetch18_data", fetch_data, 32'h1234_5678);

    // Both requesters held continuously
    glog = "";
    for (int i = 0; i < 8; i++) begin
      lqa.push_back($urandom_range(0, 255) << 2); lqd.push_back($urandom());
    end
    for (int i = 0; i < 3; i++) fq.push_back($urandom_range(0, 255) << 2);
    run_until_idle("burst", 200);
    checks++;
    assert (glog.substr(0, 9) == "LLLLFLLLLF") else begin
      failures++;
      $error("FAIL grant_order observed=%s expected=LLLLFLLLLF", glog);
    end

    // Rejected requests
    fq.push_back(32'h6);
    run_until_idle("misalign", 20);
    chk("misalign_data", fetch_data, NOP);
    lqa.push_back(MEM_SIZE - 2); lqd.push_back(32'hA5A5_A5A5);
    run_until_idle("oor_load", 20);
    fq.push_back(32'hFFFF_FFFC);
    run_until_idle("wrap_fetch", 20);

    // Flush in the READ cycle; next fetch granted in the response cycle
    flush_mode = 1; gcyc.delete();
    fq.push_back(32'h8); fq.push_back(32'hC);
    run_until_idle("flush", 40);
    flush_mode = 0;
    chk("flush_regrant_gap", 32'(gcyc[1] - gcyc[0]), 32'd2);

    // Reset during WRITE aborts the store
    old_word = ref_mem[8];
    rst_mode = 1;
    lqa.push_back(32'h20); lqd.push_back(32'hDEAD_BEEF);
    run_until_idle("rst_write", 20);
    rst_mode = 0;
    run_cycle();
    chk("rst_wdata", mem_wdata, 32'h0);
    fq.push_back(32'h20);
    run_until_idle("rst_readback", 20);
    chk("rst_readback_data", fetch_data, old_word);

    // Randomized traffic with flushes and occasional resets
    rnd_mode = 1;
    for (int c = 0; c < 800; c++) begin
      if (fq.size() == 0 && !fetch_req && $urandom_range(0, 2) == 0) fq.push_back(rand_addr());
      if (lqa.size() == 0 && !load_req && $urandom_range(0, 2) == 0) begin
        lqa.push_back(rand_addr()); lqd.push_back($urandom());
      end
      run_cycle();
    end
    rnd_mode = 0;
    run_until_idle("random_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
